// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: binary wrap-bit pointers, occupancy count, watermarks,
// standard or first-word-fall-through read port, and sticky overflow/underflow flags.
module sync_fifo_ctl #(
    parameter int FIFO_SIZE  = 32,
    parameter int LOGIC_SIZE = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 28,
    parameter int AE_THRESH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr,
    input  logic [LOGIC_SIZE-1:0]         i_wdata,
    output logic                          o_wfull,
    output logic                          o_walmost_full,
    input  logic                          i_rr,
    output logic [LOGIC_SIZE-1:0]         o_rdata,
    output logic                          o_rempty,
    output logic                          o_ralmost_empty,
    output logic [$clog2(FIFO_SIZE):0]    o_count,
    output logic                          o_overflow,
    output logic                          o_underflow,
    input  logic                          i_clr_err
);

    localparam int AW = $clog2(FIFO_SIZE);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    // Handshake: a write is taken on an edge where i_wr is high and o_wfull is low; a read
    // is taken where i_rr is high and o_rempty is low. Requests against a blocking flag are
    // dropped (no pointer or storage change) and raise the matching sticky error flag.

    logic [LOGIC_SIZE-1:0] r_mem [FIFO_SIZE];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [PW-1:0]         w_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [AW-1:0]         w_waddr;
    logic [AW-1:0]         w_raddr;

    // Flags derive only from registered pointers, so they move solely on edges or reset.
    assign w_waddr  = r_wptr[AW-1:0];
    assign w_raddr  = r_rptr[AW-1:0];
    assign w_count  = r_wptr - r_rptr;
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (w_waddr == w_raddr) && (r_wptr[AW] != r_rptr[AW]);
    assign w_wr_acc = i_wr && !w_full;
    assign w_rd_acc = i_rr && !w_empty;

    assign o_count         = w_count;
    assign o_rempty        = w_empty;
    assign o_wfull         = w_full;
    assign o_walmost_full  = (w_count >= AF_LVL);
    assign o_ralmost_empty = (w_count <= AE_LVL);
    assign o_overflow      = r_overflow;
    assign o_underflow     = r_underflow;

    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[w_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // A new error on the same edge as i_clr_err keeps the flag set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (i_wr && w_full)  || (r_overflow  && !i_clr_err);
            r_underflow <= (i_rr && w_empty) || (r_underflow && !i_clr_err);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign o_rdata = w_empty ? '0 : r_mem[w_raddr];
        end else begin : g_std
            logic [LOGIC_SIZE-1:0] r_rdata;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_rdata <= '0;
                end else if (w_rd_acc) begin
                    r_rdata <= r_mem[w_raddr];
                end
            end
            assign o_rdata = r_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Bench for sync_fifo_ctl: one standard-mode and one FWFT instance, vector table plus
// scoreboard-driven fill, stream, reset and error-flag sequences.
module tb_sync_fifo_ctl;

    localparam int DEPTH = 32;
    localparam int W     = 8;
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic         clk;
    logic         rst;

    logic         s_wr, s_rr, s_clr;
    logic [W-1:0] s_wdata;
    logic         s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
    logic [W-1:0] s_rdata;
    logic [5:0]   s_count;

    logic         f_wr, f_rr, f_clr;
    logic [W-1:0] f_wdata;
    logic         f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
    logic [W-1:0] f_rdata;
    logic [5:0]   f_count;

    int total = 0;
    int bad   = 0;
    int m_count;
    logic [W-1:0] exp_q[$];

    sync_fifo_ctl #(.FIFO_SIZE(DEPTH), .LOGIC_SIZE(W), .FWFT(0),
                    .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
        .i_clk(clk), .i_rst(rst),
        .i_wr(s_wr), .i_wdata(s_wdata), .o_wfull(s_full), .o_walmost_full(s_af),
        .i_rr(s_rr), .o_rdata(s_rdata), .o_rempty(s_empty), .o_ralmost_empty(s_ae),
        .o_count(s_count), .o_overflow(s_ovf), .o_underflow(s_unf), .i_clr_err(s_clr)
    );

    sync_fifo_ctl #(.FIFO_SIZE(DEPTH), .LOGIC_SIZE(W), .FWFT(1),
                    .AF_THRESH(AF), .AE_THRESH(AE)) u_fw (
        .i_clk(clk), .i_rst(rst),
        .i_wr(f_wr), .i_wdata(f_wdata), .o_wfull(f_full), .o_walmost_full(f_af),
        .i_rr(f_rr), .o_rdata(f_rdata), .o_rempty(f_empty), .o_ralmost_empty(f_ae),
        .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_unf), .i_clr_err(f_clr)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         wr;
        logic         rr;
        logic         clr;
        logic [W-1:0] wdata;
        int           cnt;
        logic         empty;
        logic         unf;
        logic [W-1:0] rdata;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic wr, input logic rr, input logic clr,
                                input logic [W-1:0] wd, input int cnt, input logic empty,
                                input logic unf, input logic [W-1:0] rd);
        vec_t v;
        v.wr = wr; v.rr = rr; v.clr = clr; v.wdata = wd;
        v.cnt = cnt; v.empty = empty; v.unf = unf; v.rdata = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_std();
        s_wr = 1'b0; s_rr = 1'b0; s_clr = 1'b0; s_wdata = '0;
    endtask

    task automatic check_reset_std(input string tag);
        chk({tag, "_count"}, 32'(s_count), 0);
        chk({tag, "_empty"}, 32'(s_empty), 1);
        chk({tag, "_full"},  32'(s_full),  0);
        chk({tag, "_ae"},    32'(s_ae),    1);
        chk({tag, "_af"},    32'(s_af),    0);
        chk({tag, "_ovf"},   32'(s_ovf),   0);
        chk({tag, "_unf"},   32'(s_unf),   0);
        chk({tag, "_rdata"}, 32'(s_rdata), 0);
    endtask

    // Fill the standard instance from empty with 1..DEPTH, checking watermarks per write.
    task automatic fill_std();
        for (int k = 1; k <= DEPTH; k++) begin
            s_wr = 1'b1;
            s_wdata = W'(k);
            exp_q.push_back(W'(k));
            m_count++;
            step();
            chk("fill_count", 32'(s_count), 32'(m_count));
            chk("fill_af",    32'(s_af),    32'(m_count >= AF));
            chk("fill_full",  32'(s_full),  32'(m_count == DEPTH));
        end
        s_wr = 1'b0;
    endtask

    task automatic read_std(input string name);
        logic [W-1:0] e;
        s_rr = 1'b1;
        step();
        s_rr = 1'b0;
        m_count--;
        e = exp_q.pop_front();
        chk(name, 32'(s_rdata), 32'(e));
    endtask

    initial begin
        logic [W-1:0] e;
        logic [W-1:0] d;

        idle_std();
        f_wr = 1'b0; f_rr = 1'b0; f_clr = 1'b0; f_wdata = '0;
        m_count = 0;
        rst = 1'b1;
        #2;
        check_reset_std("rst0");
        chk("rst0_fw_rdata", 32'(f_rdata), 0);
        chk("rst0_fw_empty", 32'(f_empty), 1);
        chk("rst0_fw_af",    32'(f_af),    0);
        chk("rst0_fw_full",  32'(f_full),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table: empty-FIFO read/write corners and flag clearing.
        vecs[0] = mk(1, 1, 0, 8'hAA, 1, 0, 1, 8'h00);
        vecs[1] = mk(0, 1, 0, 8'h00, 0, 1, 1, 8'hAA);
        vecs[2] = mk(0, 0, 1, 8'h00, 0, 1, 0, 8'hAA);
        vecs[3] = mk(0, 1, 1, 8'h00, 0, 1, 1, 8'hAA);
        vecs[4] = mk(0, 0, 1, 8'h00, 0, 1, 0, 8'hAA);
        vecs[5] = mk(1, 0, 0, 8'h11, 1, 0, 0, 8'hAA);
        vecs[6] = mk(1, 0, 0, 8'h22, 2, 0, 0, 8'hAA);
        vecs[7] = mk(0, 1, 0, 8'h00, 1, 0, 0, 8'h11);
        vecs[8] = mk(1, 1, 0, 8'h33, 1, 0, 0, 8'h22);
        vecs[9] = mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h33);
        for (int i = 0; i < 10; i++) begin
            s_wr = vecs[i].wr; s_rr = vecs[i].rr; s_clr = vecs[i].clr;
            s_wdata = vecs[i].wdata;
            step();
            chk($sformatf("vec%0d_count", i), 32'(s_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_empty", i), 32'(s_empty), 32'(vecs[i].empty));
            chk($sformatf("vec%0d_unf", i),   32'(s_unf),   32'(vecs[i].unf));
            chk($sformatf("vec%0d_ovf", i),   32'(s_ovf),   0);
            chk($sformatf("vec%0d_rdata", i), 32'(s_rdata), 32'(vecs[i].rdata));
            chk($sformatf("vec%0d_ae", i),    32'(s_ae),    32'(vecs[i].cnt <= AE));
        end
        idle_std();

        // Fill to full.
        fill_std();
        chk("full_ovf", 32'(s_ovf), 0);

        // Simultaneous read and write while full: read wins, write rejected.
        s_wr = 1'b1; s_rr = 1'b1; s_wdata = 8'hFF;
        step();
        idle_std();
        m_count--;
        e = exp_q.pop_front();
        chk("fullrw_rdata", 32'(s_rdata), 32'(e));
        chk("fullrw_count", 32'(s_count), 31);
        chk("fullrw_ovf",   32'(s_ovf),   1);
        read_std("after_full_read");

        // Drain to half occupancy.
        for (int i = 0; i < 14; i++) read_std("drain_rdata");
        chk("half_count", 32'(s_count), 16);

        // Streaming at half occupancy across several pointer wraps.
        for (int i = 0; i < 100; i++) begin
            d = W'($urandom_range(0, 255));
            s_wr = 1'b1; s_rr = 1'b1; s_wdata = d;
            exp_q.push_back(d);
            step();
            e = exp_q.pop_front();
            chk("stream_rdata", 32'(s_rdata), 32'(e));
            chk("stream_count", 32'(s_count), 16);
        end
        idle_std();

        for (int i = 0; i < 6; i++) read_std("drain2_rdata");
        chk("pre_rst_count", 32'(s_count), 10);
        chk("pre_rst_ovf",   32'(s_ovf),   1);

        // Asynchronous reset mid-stream, sampled before any further edge.
        s_wr = 1'b1; s_rr = 1'b1; s_wdata = 8'h5C;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_std("async_rst");
        idle_std();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_count = 0;

        // Clear on the same edge as a fresh overflow: set wins.
        fill_std();
        s_wr = 1'b1; s_clr = 1'b1; s_wdata = 8'hEE;
        step();
        chk("setwins_ovf",   32'(s_ovf),   1);
        chk("setwins_count", 32'(s_count), 32);
        s_wr = 1'b0;
        step();
        chk("clr_ovf", 32'(s_ovf), 0);
        idle_std();
        read_std("post_clr_rdata");

        // First-word-fall-through instance.
        chk("fw_idle_rdata", 32'(f_rdata), 0);
        f_wr = 1'b1; f_wdata = 8'h5A;
        step();
        f_wr = 1'b0;
        chk("fw_wr_rdata", 32'(f_rdata), 32'h5A);
        chk("fw_wr_empty", 32'(f_empty), 0);
        chk("fw_wr_count", 32'(f_count), 1);
        step();
        chk("fw_hold_rdata", 32'(f_rdata), 32'h5A);
        f_rr = 1'b1;
        step();
        f_rr = 1'b0;
        chk("fw_rd_empty", 32'(f_empty), 1);
        chk("fw_rd_rdata", 32'(f_rdata), 0);
        chk("fw_rd_unf",   32'(f_unf),   0);
        f_wr = 1'b1; f_wdata = 8'h10;
        step();
        f_wdata = 8'h20;
        step();
        f_wr = 1'b0;
        chk("fw_head1", 32'(f_rdata), 32'h10);
        chk("fw_ae",    32'(f_ae),    1);
        f_rr = 1'b1;
        step();
        chk("fw_head2", 32'(f_rdata), 32'h20);
        step();
        chk("fw_empty2", 32'(f_rdata), 0);
        step();
        f_rr = 1'b0;
        chk("fw_unf",   32'(f_unf),   1);
        chk("fw_count", 32'(f_count), 0);
        chk("fw_ovf",   32'(f_ovf),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It is the same-clock successor to the dual-clock FIFO. It buffers streams inside one clock domain, such as the SERDES framing and AXIS staging paths, where the gray-code synchronizers are unnecessary but flow-control watermarks are needed.

## Interface
Parameters:
- FIFO_SIZE, 32: depth in entries; power of two, ≥ 2.
- LOGIC_SIZE, 8: entry width in bits.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AF_THRESH, 28: o_walmost_full asserts when count ≥ AF_THRESH; range 1..FIFO_SIZE.
- AE_THRESH, 4: o_ralmost_empty asserts when count ≤ AE_THRESH; range 0..FIFO_SIZE-1.

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_wr  in  1  write request.
- i_wdata  in  LOGIC_SIZE  write data.
- o_wfull  out  1  FIFO full.
- o_walmost_full  out  1  count ≥ AF_THRESH.
- i_rr  in  1  read request.
- o_rdata  out  LOGIC_SIZE  read data.
- o_rempty  out  1  FIFO empty.
- o_ralmost_empty  out  1  count ≤ AE_THRESH.
- o_count  out  $clog2(FIFO_SIZE)+1  current occupancy, 0..FIFO_SIZE.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted while empty.
- i_clr_err  in  1  synchronous clear of both sticky flags.

## Operation
- Storage is FIFO_SIZE × LOGIC_SIZE registers and is not reset.
- w_ptr and r_ptr are binary counters of width $clog2(FIFO_SIZE)+1. The low bits address storage; the MSB is the wrap bit.
- Counters wrap modulo 2·FIFO_SIZE with no special handling.
- o_count = w_ptr − r_ptr, computed modulo 2·FIFO_SIZE.
- o_rempty = (w_ptr == r_ptr).
- o_wfull = address bits equal and wrap bits differ.
- Almost flags are compared against o_count.
- All flags are combinational from registered pointers only, never from i_wr or i_rr.
- Write accept: i_wr && !o_wfull, sampled at the edge. The entry is stored at w_ptr and w_ptr increments.
- Read accept: i_rr && !o_rempty, sampled at the edge. r_ptr increments.
- Simultaneous read and write:
  - Each request is evaluated independently against pre-edge flags.
  - Neither full nor empty: both are accepted and o_count is unchanged.
  - Full: the read is accepted and the write is rejected (no pass-through); o_overflow sets.
  - Empty: the write is accepted and the read is rejected; o_underflow sets.
- Standard mode (FWFT=0):
  - On an accepted read, o_rdata is loaded with the entry at r_ptr.
  - Otherwise o_rdata holds its value.
- FWFT mode (FWFT=1):
  - o_rdata combinationally shows the entry at r_ptr when not empty, and all-zeros when empty.
  - An accepted read pops the head.
- Error flags:
  - o_overflow sets on any edge with i_wr && o_wfull.
  - o_underflow sets on any edge with i_rr && o_rempty.
  - i_clr_err clears both flags. If a set and a clear fall on the same edge, set wins.
  - Rejected requests never change pointers or storage.
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - w_ptr = r_ptr = 0, so o_count = 0, o_rempty = 1, o_wfull = 0.
  - o_ralmost_empty = 1, o_walmost_full = 0 (with AF_THRESH ≥ 1).
  - o_overflow = o_underflow = 0, o_rdata = 0.
  - Stored data is discarded logically. Release is synchronous to i_clk in the surrounding design.

## Timing
- Write to empty: accepted at edge n; o_rempty falls and o_count = 1 after edge n.
  - FWFT: o_rdata is valid in the same cycle.
- Standard read: accepted at edge n; o_rdata is valid after edge n (1-cycle latency).
- Full after FIFO_SIZE consecutive accepted writes with no reads; o_wfull rises after the final write edge.
- Flags and o_count change only on clock edges or on asynchronous reset.
- Sustained throughput is one write and one read per cycle.

## Test plan
- Reset, then write 0x01..0x20 on 32 consecutive cycles (FIFO_SIZE=32) -> o_count reaches 32, o_wfull = 1, o_walmost_full asserts after the 28th write, o_overflow stays 0.
- From full, assert i_wr and i_rr together for one cycle -> read accepted, write rejected, o_count = 31, o_overflow = 1, and the next standard-mode read returns 0x02.
- From empty, assert i_wr = 1 (0xAA) and i_rr = 1 together -> o_count = 1, o_underflow = 1; the following read returns 0xAA and the FIFO is empty again.
- FWFT=1: write 0x5A into empty -> o_rdata = 0x5A on the next cycle with no read; one read -> o_rempty = 1 and o_rdata = 0x00.
- Streaming: simultaneous read and write for 100 cycles with random data at half occupancy, crossing pointer wrap at least 3 times -> o_count constant at 16 and output order matches the scoreboard.
- Assert i_rst mid-stream at count = 10 with o_overflow = 1 -> all outputs reach reset values immediately, without waiting for a clock edge. Then i_clr_err on the same edge as a new overflow -> o_overflow remains 1.
